nonbin_class_updater: RTL and testbench

- Read-modify-write engine that drives the write side of the nonbinary class HV segment register.
- On `start`, it walks all SEQ_CYCLE_COUNT segments of the stored class HV.
- For each segment it reads the current value, adds or subtracts one streamed binary query segment per dimension, and writes the result back.
- Sits between the training controller (start/op) and the query encoder (segment stream).

---
 rtl/nonbin_class_updater_pkg.sv | 29 ++
 rtl/nonbin_dim_addsub.sv | 51 +++++
 rtl/nonbin_class_updater.sv | 114 +++++++++++
 tb/tb_nonbin_class_updater.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonbin_class_updater_pkg.sv
// Shared definitions for the nonbinary class HV updater.
// Contents: segment geometry constants, the segment payload type
// (nonbin_seg_t) and the updater FSM state type (upd_state_e).
// Configuration: NONBIN_CLASS_UPD_SAT_EN selects saturating arithmetic
// (defined) or modulo wrap (undefined, default) in nonbin_dim_addsub.
package nonbin_class_updater_pkg;

   // Segment geometry
   localparam int unsigned DIMS_PER_CC      = 500;
   localparam int unsigned BITWIDTH_PER_DIM = 9;
   localparam int unsigned SEQ_CYCLE_COUNT  = 10;

   // Segment index width; covers up to 16 segments per class HV
   localparam int unsigned SEG_IDX_W = 4;

   // Index of the final segment of a pass
   localparam logic [SEG_IDX_W-1:0] LAST_SEG_IDX = SEG_IDX_W'(SEQ_CYCLE_COUNT - 1);

   // One class HV segment: DIMS_PER_CC signed dimensions, dimension d at [d]
   typedef logic [DIMS_PER_CC-1:0][BITWIDTH_PER_DIM-1:0] nonbin_seg_t;

   // Updater pass state
   typedef enum logic [1:0] {
      UPD_IDLE = 2'd0,
      UPD_RUN  = 2'd1,
      UPD_DONE = 2'd2
   } upd_state_e;

endpackage

// File: rtl/nonbin_dim_addsub.sv
// Single-dimension +1 / -1 / hold for one class HV dimension.
// Ports:
//   val_i  current signed dimension value (W bits)
//   act_i  query bit for this dimension; 0 leaves the value unchanged
//   sub_i  1 = subtract, 0 = add
//   res_o  updated value (W bits)
// Configuration: NONBIN_CLASS_UPD_SAT_EN defined -> clamp to the signed
// W-bit range; undefined -> wrap modulo 2^W.
module nonbin_dim_addsub
   import nonbin_class_updater_pkg::*;
#(
   parameter int unsigned W = BITWIDTH_PER_DIM
)
(
   input  logic [W-1:0] val_i,
   input  logic         act_i,
   input  logic         sub_i,
   output logic [W-1:0] res_o
);

   logic [W:0] delta;
   logic [W:0] sum;

   // Delta of +1, -1 (all ones) or 0 at the extended width
   always_comb begin
      delta = '0;
      if (act_i) begin
         delta = sub_i ? '1 : (W+1)'(1);
      end
   end

   // Sign-extend by one bit so the true sign survives overflow
   assign sum = {val_i[W-1], val_i} + delta;

`ifdef NONBIN_CLASS_UPD_SAT_EN
   // Top two bits disagree only on overflow; sum[W] holds the true sign
   always_comb begin
      res_o = sum[W-1:0];
      if (sum[W] != sum[W-1]) begin
         res_o = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end
`else
   logic unused_sum_msb;

   // Wrap: dropping the extension bit is the modulo-2^W result
   assign unused_sum_msb = sum[W];
   assign res_o          = sum[W-1:0];
`endif

endmodule

// File: rtl/nonbin_class_updater.sv
// Read-modify-write engine for the nonbinary class HV segment register.
// A pass walks all SEQ_CYCLE_COUNT segments: for each accepted query beat it
// reads segment seg_ctr, applies +/-1 per active query dimension, and writes
// the result back one cycle later.
// Ports:
//   clk, nrst   clock, asynchronous active-low reset
//   start_i     begin a pass (ignored unless idle); sub_op_i sampled with it
//   abort_i     synchronous cancel of an active pass
//   q_valid_i / q_ready_o / q_seg_i   query segment stream
//   rd_idx_o / rd_data_i              class register read port (comb data)
//   wr_en_o / wr_idx_o / wr_data_o    class register write port (registered)
//   busy_o      pass in progress; done_o one-cycle completion pulse
// Configuration: NONBIN_CLASS_UPD_SAT_EN enables saturating arithmetic.
module nonbin_class_updater
   import nonbin_class_updater_pkg::*;
(
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start_i,
   input  logic                  sub_op_i,
   input  logic                  abort_i,
   input  logic                  q_valid_i,
   output logic                  q_ready_o,
   input  logic [DIMS_PER_CC-1:0] q_seg_i,
   output logic [SEG_IDX_W-1:0]  rd_idx_o,
   input  nonbin_seg_t           rd_data_i,
   output logic                  wr_en_o,
   output logic [SEG_IDX_W-1:0]  wr_idx_o,
   output nonbin_seg_t           wr_data_o,
   output logic                  busy_o,
   output logic                  done_o
);

   upd_state_e            state_q;
   logic [SEG_IDX_W-1:0]  seg_ctr_q;
   logic                  op_q;
   logic                  wr_en_q;
   logic [SEG_IDX_W-1:0]  wr_idx_q;
   nonbin_seg_t           wr_data_q;
   nonbin_seg_t           wr_data_d;

   logic in_run;
   logic accept;
   logic last_seg;

   // Abort wins over a coincident beat, so it also gates acceptance
   assign in_run   = (state_q == UPD_RUN);
   assign accept   = in_run & q_valid_i & ~abort_i;
   assign last_seg = (seg_ctr_q == LAST_SEG_IDX);

   // Per-dimension update of the segment currently being read
   for (genvar d = 0; d < DIMS_PER_CC; d++) begin : g_dim
      nonbin_dim_addsub #(
         .W (BITWIDTH_PER_DIM)
      ) u_addsub (
         .val_i (rd_data_i[d]),
         .act_i (q_seg_i[d]),
         .sub_i (op_q),
         .res_o (wr_data_d[d])
      );
   end

   // Pass FSM, segment counter and registered write port
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= UPD_IDLE;
         seg_ctr_q <= '0;
         op_q      <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_idx_q  <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= accept;
         // Write target is always the segment just read, so no RAW hazard
         if (accept) begin
            wr_idx_q  <= seg_ctr_q;
            wr_data_q <= wr_data_d;
            seg_ctr_q <= seg_ctr_q + SEG_IDX_W'(1);
         end
         case (state_q)
            UPD_IDLE: begin
               if (start_i) begin
                  state_q   <= UPD_RUN;
                  op_q      <= sub_op_i;
                  seg_ctr_q <= '0;
               end
            end
            UPD_RUN: begin
               if (abort_i) begin
                  state_q <= UPD_IDLE;
               end else if (accept && last_seg) begin
                  state_q <= UPD_DONE;
               end
            end
            UPD_DONE: begin
               state_q <= UPD_IDLE;
            end
            default: begin
               state_q <= UPD_IDLE;
            end
         endcase
      end
   end

   // Output decode of the registered state
   assign q_ready_o = in_run & ~abort_i;
   assign rd_idx_o  = in_run ? seg_ctr_q : '0;
   assign wr_en_o   = wr_en_q;
   assign wr_idx_o  = wr_idx_q;
   assign wr_data_o = wr_data_q;
   assign busy_o    = (state_q == UPD_RUN) || (state_q == UPD_DONE);
   assign done_o    = (state_q == UPD_DONE);

endmodule

// File: tb/tb_nonbin_class_updater.sv
// Randomized self-checking bench for nonbin_class_updater.
// Holds the class register image driven by the DUT write port and an
// integer reference model of the class HV and of the pass protocol.
module tb_nonbin_class_updater;
   import nonbin_class_updater_pkg::*;

   localparam int ND   = int'(DIMS_PER_CC);
   localparam int NS   = int'(SEQ_CYCLE_COUNT);
   localparam int SPAN = 1 << BITWIDTH_PER_DIM;
   localparam int VMAX = (1 << (BITWIDTH_PER_DIM - 1)) - 1;
   localparam int VMIN = -(1 << (BITWIDTH_PER_DIM - 1));

   logic                 clk = 1'b0;
   logic                 nrst = 1'b0;
   logic                 start = 1'b0;
   logic                 sub_op = 1'b0;
   logic                 abort = 1'b0;
   logic                 q_valid = 1'b0;
   logic                 q_ready;
   logic [ND-1:0]        q_seg = '0;
   logic [SEG_IDX_W-1:0] rd_idx;
   nonbin_seg_t          rd_data;
   logic                 wr_en;
   logic [SEG_IDX_W-1:0] wr_idx;
   nonbin_seg_t          wr_data;
   logic                 busy;
   logic                 done;

   // Class register image: written by the DUT, preloadable by the bench
   nonbin_seg_t mem_reg  [NS];
   nonbin_seg_t load_img [NS];
   logic        tb_load = 1'b0;

   // Reference model
   int   ref_v [NS][ND];
   int   exp_v [ND];
   int   exp_idx;
   logic exp_wr;
   int   m_phase;   // 0 idle, 1 walking segments, 2 completion cycle
   int   m_seg;
   logic m_sub;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   nonbin_class_updater dut (
      .clk       (clk),
      .nrst      (nrst),
      .start_i   (start),
      .sub_op_i  (sub_op),
      .abort_i   (abort),
      .q_valid_i (q_valid),
      .q_ready_o (q_ready),
      .q_seg_i   (q_seg),
      .rd_idx_o  (rd_idx),
      .rd_data_i (rd_data),
      .wr_en_o   (wr_en),
      .wr_idx_o  (wr_idx),
      .wr_data_o (wr_data),
      .busy_o    (busy),
      .done_o    (done)
   );

   assign rd_data = (int'(rd_idx) < NS) ? mem_reg[rd_idx] : '0;

   always @(posedge clk) begin
      if (tb_load) begin
         for (int s = 0; s < NS; s++) mem_reg[s] <= load_img[s];
      end else if (wr_en && (int'(wr_idx) < NS)) begin
         mem_reg[wr_idx] <= wr_data;
      end
   end

   task automatic chk(input string tag, input longint got, input longint want);
      n_total++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
      end
   endtask

   // +/-1 on a signed dimension with clamp or wrap
   function automatic int upd(input int v, input logic act, input logic sub);
      int r;
      r = v + (act ? (sub ? -1 : 1) : 0);
`ifdef NONBIN_CLASS_UPD_SAT_EN
      if (r > VMAX) r = VMAX;
      if (r < VMIN) r = VMIN;
`else
      if (r > VMAX) r -= SPAN;
      if (r < VMIN) r += SPAN;
`endif
      return r;
   endfunction

   task automatic check_outputs();
      int bad_d;
      bit found;
      chk("wr_en", longint'(wr_en), longint'(exp_wr));
      chk("wr_idx", longint'(wr_idx), longint'(exp_idx));
      bad_d = 0;
      found = 1'b0;
      for (int d = 0; d < ND; d++) begin
         if (!found && (int'($signed(wr_data[d])) != exp_v[d])) begin
            bad_d = d;
            found = 1'b1;
         end
      end
      chk("wr_data", longint'($signed(wr_data[bad_d])), longint'(exp_v[bad_d]));
      chk("busy", longint'(busy), longint'(m_phase != 0));
      chk("done", longint'(done), longint'(m_phase == 2));
      chk("rd_idx", longint'(rd_idx), longint'((m_phase == 1) ? m_seg : 0));
   endtask

   // One clock: check, drive, advance the model; entered and left at negedge
   task automatic step(input logic st, input logic so, input logic ab,
                       input logic qv, input logic [ND-1:0] qs);
      check_outputs();
      if (exp_wr) begin
         for (int d = 0; d < ND; d++) ref_v[exp_idx][d] = exp_v[d];
      end
      start   = st;
      sub_op  = so;
      abort   = ab;
      q_valid = qv;
      q_seg   = qs;
      #1;
      chk("q_ready", longint'(q_ready), longint'((m_phase == 1) && !ab));
      exp_wr = 1'b0;
      case (m_phase)
         0: if (st) begin
               m_phase = 1;
               m_seg   = 0;
               m_sub   = so;
            end
         1: if (ab) begin
               m_phase = 0;
            end else if (qv) begin
               exp_wr  = 1'b1;
               exp_idx = m_seg;
               for (int d = 0; d < ND; d++) exp_v[d] = upd(ref_v[m_seg][d], qs[d], m_sub);
               m_seg++;
               if (m_seg == NS) m_phase = 2;
            end
         default: m_phase = 0;
      endcase
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic do_reset();
      nrst    = 1'b0;
      start   = 1'b0;
      sub_op  = 1'b0;
      abort   = 1'b0;
      q_valid = 1'b0;
      q_seg   = '0;
      #1;
      m_phase = 0;
      m_seg   = 0;
      m_sub   = 1'b0;
      exp_wr  = 1'b0;
      exp_idx = 0;
      for (int d = 0; d < ND; d++) exp_v[d] = 0;
      check_outputs();
      chk("q_ready_rst", longint'(q_ready), 0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
   endtask

   // mode 0: all zero, 1: random with frequent extremes
   task automatic fill_ref(input int mode);
      int r;
      for (int s = 0; s < NS; s++) begin
         for (int d = 0; d < ND; d++) begin
            r = int'($urandom_range(7));
            if (mode == 0)   ref_v[s][d] = 0;
            else if (r == 0) ref_v[s][d] = VMIN;
            else if (r == 1) ref_v[s][d] = VMAX;
            else             ref_v[s][d] = int'($urandom_range(SPAN - 1)) + VMIN;
         end
      end
   endtask

   task automatic load_mem();
      idle(2);
      for (int s = 0; s < NS; s++) begin
         for (int d = 0; d < ND; d++) load_img[s][d] = BITWIDTH_PER_DIM'(ref_v[s][d]);
      end
      tb_load = 1'b1;
      @(negedge clk);
      tb_load = 1'b0;
   endtask

   // vmode 0: valid always, 1: pattern 1,0,0,1, 2: random 70%
   // qmode 0: all ones, 1: random bits
   // noise 0: none, 1: one opposite-op start at cycle 3, 2: random starts
   task automatic run_pass(input logic sub, input int vmode, input int qmode,
                           input int noise, input int abort_at, input int rst_at);
      logic [ND-1:0] qs;
      logic          qv, st, ab;
      int            cyc;
      bit            stop;
      step(1'b1, sub, 1'b0, 1'b0, '0);
      cyc  = 0;
      stop = 1'b0;
      while (!stop && (m_phase != 0) && (cyc < 400)) begin
         if (rst_at >= 0 && m_phase == 1 && m_seg == rst_at) begin
            do_reset();
            stop = 1'b1;
         end else begin
            case (vmode)
               0:       qv = 1'b1;
               1:       qv = ((cyc % 4) == 0) || ((cyc % 4) == 3);
               default: qv = ($urandom_range(99) < 70);
            endcase
            for (int d = 0; d < ND; d++) qs[d] = (qmode == 0) ? 1'b1 : 1'($urandom_range(1));
            st = ((noise == 1) && (cyc == 3)) || ((noise == 2) && ($urandom_range(9) == 0));
            ab = (abort_at >= 0) && (m_phase == 1) && (m_seg == abort_at);
            if (ab) qv = 1'b1;
            step(st, ~sub, ab, qv, qs);
            cyc++;
         end
      end
      if (m_phase != 0) chk("pass_timeout", longint'(cyc), -1);
      idle(2);
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // Add pass over zeros with every query bit set
      fill_ref(0);
      load_mem();
      run_pass(1'b0, 0, 0, 0, -1, -1);
      chk("add_ones_seg0", longint'($signed(mem_reg[0][0])), 1);
      chk("add_ones_seg9", longint'($signed(mem_reg[NS-1][ND-1])), 1);

      // Subtract from the most negative value
      fill_ref(0);
      ref_v[3][0] = VMIN;
      load_mem();
      run_pass(1'b1, 0, 0, 0, -1, -1);
`ifdef NONBIN_CLASS_UPD_SAT_EN
      chk("sub_min_edge", longint'($signed(mem_reg[3][0])), -256);
`else
      chk("sub_min_edge", longint'($signed(mem_reg[3][0])), 255);
`endif
      chk("sub_zero_dim", longint'($signed(mem_reg[3][1])), -1);

      // Add to the most positive value
      fill_ref(0);
      ref_v[3][0] = VMAX;
      load_mem();
      run_pass(1'b0, 0, 0, 0, -1, -1);
`ifdef NONBIN_CLASS_UPD_SAT_EN
      chk("add_max_edge", longint'($signed(mem_reg[3][0])), 255);
`else
      chk("add_max_edge", longint'($signed(mem_reg[3][0])), -256);
`endif

      // Stalls with q_valid 1,0,0,1
      fill_ref(1);
      load_mem();
      run_pass(1'b0, 1, 1, 0, -1, -1);

      // Abort coincident with the beat for segment 4
      run_pass(1'b0, 0, 1, 0, 4, -1);
      idle(3);

      // start during a pass is ignored, then a fresh subtract pass
      run_pass(1'b0, 0, 1, 1, -1, -1);
      run_pass(1'b1, 0, 1, 0, -1, -1);

      // Reset at segment 6, then a new pass from segment 0
      run_pass(1'b0, 0, 1, 0, -1, 6);
      run_pass(1'b1, 2, 1, 0, -1, -1);

      // Random passes
      for (int p = 0; p < 20; p++) begin
         if ((p % 5) == 0) begin
            fill_ref(1);
            load_mem();
         end
         run_pass(1'($urandom_range(1)), 2, 1, 2,
                  ($urandom_range(3) == 0) ? int'($urandom_range(NS - 1)) : -1, -1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
